// File: rtl/param_sync_fifo.sv
// rtl/param_sync_fifo.sv - parameterised single-clock FIFO with level flags, sticky errors and FWFT option
module param_sync_fifo #(
   parameter int DATA_WIDTH = 8,
   parameter int ADDR_WIDTH = 3,
   parameter int AF_LEVEL   = 6,
   parameter int AE_LEVEL   = 2,
   parameter int FWFT       = 0
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  push,
   input  logic                  pop,
   input  logic [DATA_WIDTH-1:0] data_in,
   output logic [DATA_WIDTH-1:0] data_out,
   output logic                  empty,
   output logic                  full,
   output logic                  almost_empty,
   output logic                  almost_full,
   output logic [ADDR_WIDTH:0]   fifo_counter,
   output logic                  overflow,
   output logic                  underflow,
   input  logic                  clr_err
);

   localparam int DEPTH = 2 ** ADDR_WIDTH;
   localparam int CW    = ADDR_WIDTH + 1;
   localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
   localparam logic [CW-1:0] AF_C    = CW'(AF_LEVEL);
   localparam logic [CW-1:0] AE_C    = CW'(AE_LEVEL);

   logic [DATA_WIDTH-1:0] mem_q [DEPTH];
   logic [ADDR_WIDTH-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
   logic [CW-1:0]         count_q, count_d;
   logic                  ovf_q, ovf_d, udf_q, udf_d;
   logic                  pop_ok, push_ok;

   assign empty        = (count_q == '0);
   assign full         = (count_q == DEPTH_C);
   assign almost_empty = (count_q <= AE_C);
   assign almost_full  = (count_q >= AF_C);
   assign fifo_counter = count_q;
   assign overflow     = ovf_q;
   assign underflow    = udf_q;

   // A push into a full FIFO is still legal when a pop frees a slot in the same cycle.
   always_comb begin
      pop_ok  = pop & ~empty;
      push_ok = push & (~full | pop_ok);
      wptr_d  = wptr_q;
      rptr_d  = rptr_q;
      count_d = count_q;
      if (push_ok) wptr_d = wptr_q + ADDR_WIDTH'(1);
      if (pop_ok)  rptr_d = rptr_q + ADDR_WIDTH'(1);
      unique case ({push_ok, pop_ok})
         2'b10:   count_d = count_q + CW'(1);
         2'b01:   count_d = count_q - CW'(1);
         default: count_d = count_q;
      endcase
      ovf_d = (ovf_q & ~clr_err) | (push & ~push_ok);
      udf_d = (udf_q & ~clr_err) | (pop & ~pop_ok);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wptr_q  <= '0;
         rptr_q  <= '0;
         count_q <= '0;
         ovf_q   <= 1'b0;
         udf_q   <= 1'b0;
      end else begin
         wptr_q  <= wptr_d;
         rptr_q  <= rptr_d;
         count_q <= count_d;
         ovf_q   <= ovf_d;
         udf_q   <= udf_d;
      end
   end

   // Storage is deliberately left out of reset.
   always_ff @(posedge clk) begin
      if (push_ok && !rst) mem_q[wptr_q] <= data_in;
   end

   if (FWFT != 0) begin : g_fwft
      assign data_out = empty ? '0 : mem_q[rptr_q];
   end else begin : g_reg
      logic [DATA_WIDTH-1:0] dout_q, dout_d;

      always_comb begin
         dout_d = dout_q;
         if (pop_ok) dout_d = mem_q[rptr_q];
      end

      always_ff @(posedge clk or posedge rst) begin
         if (rst) dout_q <= '0;
         else     dout_q <= dout_d;
      end

      assign data_out = dout_q;
   end

endmodule

// File: doc/param_sync_fifo.md
PARAM_SYNC_FIFO -- requirements
Module: param_sync_fifo

Interface
REQ-001 Parameters SHALL be as follows; DEPTH = 2**ADDR_WIDTH; legal only if 0 <= AE_LEVEL < AF_LEVEL <= DEPTH:
- DATA_WIDTH, 8, word width in bits.
- ADDR_WIDTH, 3, pointer width in bits.
- AF_LEVEL, 6, almost-full threshold in words.
- AE_LEVEL, 2, almost-empty threshold in words.
- FWFT, 0, read mode: 0 = registered read, 1 = first-word-fall-through.

REQ-002 Ports SHALL be as follows:
- clk, input, 1, single clock; all state updates on the rising edge.
- rst, input, 1, asynchronous, active-high reset.
- push, input, 1, write request.
- pop, input, 1, read request.
- data_in, input, DATA_WIDTH, write data.
- data_out, output, DATA_WIDTH, read data.
- empty, output, 1, count == 0.
- full, output, 1, count == DEPTH.
- almost_empty, output, 1, count <= AE_LEVEL.
- almost_full, output, 1, count >= AF_LEVEL.
- fifo_counter, output, ADDR_WIDTH+1, words stored (0..DEPTH).
- overflow, output, 1, sticky: push was rejected.
- underflow, output, 1, sticky: pop was rejected.
- clr_err, input, 1, synchronous clear of overflow and underflow.

Function
REQ-003 Pop SHALL be accepted iff pop=1 and empty=0.
REQ-004 Push SHALL be accepted iff push=1 and (full=0 or pop is accepted in the same cycle).
REQ-005 An accepted push SHALL write data_in at the write pointer and advance the write pointer by 1, wrapping modulo DEPTH.
REQ-006 An accepted pop SHALL advance the read pointer by 1, wrapping modulo DEPTH.
REQ-007 fifo_counter SHALL update as follows: +1 on push only, -1 on pop only, unchanged when both or neither are accepted; it never exceeds DEPTH and never goes below 0.
REQ-008 empty, full, almost_empty and almost_full SHALL be combinational decodes of the registered fifo_counter, so they reflect the post-edge count.
REQ-009 With FWFT=0, data_out SHALL be registered; on an accepted pop it loads the head word, visible after the same edge (one-cycle read latency); otherwise it holds its value.
REQ-010 With FWFT=1, data_out SHALL show the head word whenever empty=0 and SHALL be 0 when empty=1; an accepted pop makes the next word visible after the edge.
REQ-011 A simultaneous push and pop at count 0 SHALL accept the push only and set underflow.
REQ-012 A simultaneous push and pop at count DEPTH SHALL accept both, leaving the count at DEPTH.
REQ-013 Data order SHALL be strictly FIFO across any number of pointer wrap-arounds.
REQ-014 overflow SHALL set on any rejected push, and underflow SHALL set on any rejected pop; both hold until clr_err or rst.
REQ-015 If clr_err coincides with a new error in the same cycle, the flag SHALL end the cycle set (set has priority over clear).
REQ-016 A rejected push or pop SHALL NOT change pointers, count, memory or data_out.

Reset
REQ-017 rst=1 SHALL immediately, without waiting for a clock edge, force: pointers=0, fifo_counter=0, data_out=0, overflow=0, underflow=0, empty=1, almost_empty=1, full=0, almost_full=0.
REQ-018 Storage memory SHALL NOT be reset.
REQ-019 Asserting rst mid-operation SHALL discard all stored words.
REQ-020 Pushes and pops presented while rst=1 SHALL be ignored.
REQ-021 Normal operation SHALL resume on the first rising edge after rst deasserts.

Verification (defaults unless stated)
REQ-022 Reset: assert rst with push=1 -> all outputs at REQ-017 values, counter stays 0.
REQ-023 Fill to full:
- push 0xFF,0xF0,0xFA,0xAA,0xF1,0x0F,0xF5,0x05 -> almost_full=1 after the 6th push, full=1 and counter=8 after the 8th.
- a 9th push of 0x15 -> overflow=1, counter=8.
REQ-024 Drain:
- 8 pops (FWFT=0) -> data_out shows 0xFF..0x05 in order, each one cycle after its pop; empty=1 after the 8th.
- a 9th pop -> underflow=1, data_out holds 0x05.
- clr_err -> both flags 0.
REQ-025 Simultaneous push and pop:
- at counter=3 -> counter stays 3, order preserved.
- at full -> both accepted, counter=8.
- at empty -> counter=1, underflow=1.
REQ-026 Wrap-around: 20 interleaved pushes/pops keeping the count between 2 and 6 -> output sequence equals input sequence; flags match the count every cycle.
REQ-027 FWFT=1 and mid-stream reset:
- push 0xA5 into an empty FIFO -> data_out=0xA5 the next cycle without a pop.
- pulse rst between edges with counter=5 -> counter=0 and empty=1 before the next edge.
